// File: rtl/core_pkg.sv
// Shared types and sizes for the rename stage: tag widths, map storage type and
// the renamed-instruction record handed to dispatch.
package core_pkg;
  localparam int PREGS     = 48;
  localparam int ARCH_REGS = 32;
  localparam int XZR_IDX   = 31;
  localparam int PW        = 6;

  typedef logic [PW-1:0] preg_t;
  typedef logic [4:0]    areg_t;
  typedef preg_t [ARCH_REGS-1:0] map_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic  rd_we;
  } rename_out_t;

  // Identity mapping Xi -> Pi, the state both maps wake up in.
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REGS; i++) m[i] = preg_t'(i);
    return m;
  endfunction
endpackage

// File: rtl/map_table.sv
// 32-entry architectural-to-physical map: async read ports, one write port and
// a whole-table load. Entry XZR is pinned to its identity tag.
module map_table
  import core_pkg::*;
#(
  parameter int NRD = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  areg_t [NRD-1:0]   raddr,
  output preg_t [NRD-1:0]   rdata,
  input  logic              we,
  input  areg_t             waddr,
  input  preg_t             wdata,
  input  logic              load_en,
  input  map_t              load_data,
  output map_t              map_next
);
  map_t map_q, map_d;

  always_comb begin
    map_d = map_q;
    if (load_en) begin
      map_d = load_data;
    end else if (we) begin
      map_d[waddr] = wdata;
    end
    map_d[XZR_IDX] = preg_t'(XZR_IDX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      map_q <= identity_map();
    end else begin
      map_q <= map_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g] = map_q[raddr[g]];
  end

  // Post-update view, so a consumer can copy the table including this cycle's write.
  assign map_next = map_d;
endmodule

// File: rtl/rename_map.sv
// Single-issue rename stage: speculative and committed maps, free-list pop per
// architectural write, one-entry output register towards dispatch.
module rename_map
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  areg_t in_rs1,
  input  areg_t in_rs2,
  input  areg_t in_rd,
  input  logic  in_rd_we,
  output logic  fl_alloc_en,
  input  preg_t fl_alloc_phys,
  input  logic  fl_alloc_valid,
  output logic  fl_free_en,
  output preg_t fl_free_phys,
  output logic  out_valid,
  input  logic  out_ready,
  output preg_t out_prs1,
  output preg_t out_prs2,
  output preg_t out_prd,
  output preg_t out_old_prd,
  output logic  out_rd_we,
  input  logic  commit_en,
  input  logic  commit_rd_we,
  input  areg_t commit_rd,
  input  preg_t commit_prd,
  input  preg_t commit_old_prd,
  input  logic  flush
);
  // Handshake: in_valid/in_ready and out_valid/out_ready are standard valid/ready
  // pairs; a beat moves on the posedge where both are high, and a holder of valid
  // keeps its payload stable until ready is seen.
  rename_out_t out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        need_alloc, fire, commit_write;
  areg_t [2:0] spec_raddr;
  preg_t [2:0] spec_rdata;
  areg_t [0:0] arch_raddr;
  preg_t [0:0] arch_rdata;
  map_t        arch_next, spec_next;

  assign need_alloc   = in_rd_we && (in_rd != areg_t'(XZR_IDX));
  assign in_ready     = reset && !flush && (!out_valid_q || out_ready)
                        && (!need_alloc || fl_alloc_valid);
  assign fire         = in_valid && in_ready;
  assign fl_alloc_en  = fire && need_alloc;
  assign commit_write = commit_en && commit_rd_we && (commit_rd != areg_t'(XZR_IDX));
  assign fl_free_en   = commit_write;
  assign fl_free_phys = commit_old_prd;

  assign spec_raddr = {in_rd, in_rs2, in_rs1};
  assign arch_raddr = areg_t'(XZR_IDX);

  map_table #(.NRD(3)) u_spec (
    .clk       (clk),
    .reset     (reset),
    .raddr     (spec_raddr),
    .rdata     (spec_rdata),
    .we        (fire && need_alloc),
    .waddr     (in_rd),
    .wdata     (fl_alloc_phys),
    .load_en   (flush),
    .load_data (arch_next),
    .map_next  (spec_next)
  );

  // Flush copies the committed map including the commit retiring this same cycle.
  map_table #(.NRD(1)) u_arch (
    .clk       (clk),
    .reset     (reset),
    .raddr     (arch_raddr),
    .rdata     (arch_rdata),
    .we        (commit_write),
    .waddr     (commit_rd),
    .wdata     (commit_prd),
    .load_en   (1'b0),
    .load_data ('0),
    .map_next  (arch_next)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d   = 1'b1;
      out_d.prs1    = spec_rdata[0];
      out_d.prs2    = spec_rdata[1];
      out_d.old_prd = spec_rdata[2];
      out_d.prd     = need_alloc ? fl_alloc_phys : '0;
      out_d.rd_we   = need_alloc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && commit_en && commit_rd_we) begin
      assert (int'(commit_prd) < PREGS && int'(commit_old_prd) < PREGS)
        else $error("rename_map: commit tag out of range");
    end
    if (reset) begin
      assert (arch_rdata[0] == preg_t'(XZR_IDX) && spec_next[XZR_IDX] == preg_t'(XZR_IDX))
        else $error("rename_map: XZR mapping disturbed");
    end
  end

  assign out_valid   = out_valid_q;
  assign out_prs1    = out_q.prs1;
  assign out_prs2    = out_q.prs2;
  assign out_prd     = out_q.prd;
  assign out_old_prd = out_q.old_prd;
  assign out_rd_we   = out_q.rd_we;
endmodule
